// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: instruction width, PC step and the fetch FSM
// state encoding.
package fetch_unit_pkg;

  localparam int unsigned INS_W  = 32;
  localparam int unsigned PC_INC = 4;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_FULL  = 2'd1,
    ST_REDIR = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_queue.sv
// Synchronous FIFO holding {pc, instruction} pairs between fetch and decode.
// A flush empties it at the clock edge, taking priority over push and pop.
module fetch_queue #(
  parameter int W     = 47,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wp] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) r_wp <= r_wp + PW'(1);
      if (pop)  r_rp <= r_rp + PW'(1);
      r_cnt <= r_cnt + CW'(push) - CW'(pop);
    end
  end

  assign rdata = r_mem[r_rp];
  assign empty = (r_cnt == '0);
  assign full  = (r_cnt == CW'(DEPTH));
  assign count = r_cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word fetches, tracks one in-flight request
// with an epoch tag, and queues returned instructions for decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 15,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [INS_W-1:0]  imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  output logic [INS_W-1:0]  out_ins,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready
);

  localparam int                CW         = $clog2(QDEPTH) + 1;
  localparam int                QW         = ADDR_W + INS_W;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_epoch;
  logic              r_inflight;
  logic              r_inf_epoch;
  logic [ADDR_W-1:0] r_inf_pc;

  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_q_empty;
  logic              w_q_full;
  logic [CW-1:0]     w_q_count;
  logic [QW-1:0]     w_q_rdata;
  logic [CW:0]       w_cnt_next;
  logic [CW:0]       w_sum_next;
  logic              w_full_next;

  assign w_accept = imem_req && imem_ready;
  // Only a response from the current epoch is kept; the redirect cycle drops all.
  assign w_push   = imem_rvalid && r_inflight && (r_inf_epoch == r_epoch) && !redirect;
  assign w_pop    = out_valid && out_ready;

  assign out_valid = !w_q_empty && !redirect && !rst;
  assign out_pc    = w_q_rdata[QW-1:INS_W];
  assign out_ins   = w_q_rdata[INS_W-1:0];

  // FULL still issues when decode frees a slot this cycle.
  assign imem_req  = !rst && ((r_state != ST_FULL) || w_pop);
  assign imem_addr = r_pc & ALIGN_MASK;

  // Credit for next cycle, before knowing next cycle's pop.
  assign w_cnt_next  = {1'b0, w_q_count} + (CW+1)'(w_push) - (CW+1)'(w_pop);
  assign w_sum_next  = w_cnt_next + (CW+1)'(w_accept);
  assign w_full_next = (w_sum_next >= (CW+1)'(QDEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_FETCH;
      r_pc        <= RESET_PC;
      r_epoch     <= 1'b0;
      r_inflight  <= 1'b0;
      r_inf_epoch <= 1'b0;
      r_inf_pc    <= '0;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) begin
        r_inf_epoch <= r_epoch;
        r_inf_pc    <= imem_addr;
      end
      if (redirect) begin
        r_state <= ST_REDIR;
        r_pc    <= redirect_pc & ALIGN_MASK;
        r_epoch <= ~r_epoch;
      end else begin
        if (w_accept) r_pc <= r_pc + ADDR_W'(PC_INC);
        case (r_state)
          ST_REDIR: if (w_accept) r_state <= ST_FETCH;
          default:  r_state <= w_full_next ? ST_FULL : ST_FETCH;
        endcase
      end
    end
  end

  fetch_queue #(
    .W     (QW),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (w_push),
    .wdata ({r_inf_pc, imem_rdata}),
    .pop   (w_pop),
    .rdata (w_q_rdata),
    .empty (w_q_empty),
    .full  (w_q_full),
    .count (w_q_count)
  );

  always @(posedge clk) begin
    if (!rst && w_push) assert (!w_q_full);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model returns the request address as
// the instruction word, one cycle after acceptance.
module tb_fetch_unit;

  localparam int ADDR_W = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready = 1'b0;
  logic              imem_rvalid = 1'b0;
  logic [31:0]       imem_rdata = '0;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              out_valid;
  logic [31:0]       out_ins;
  logic [ADDR_W-1:0] out_pc;
  logic              out_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic              mem_acc = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC('0), .QDEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ins(out_ins), .out_pc(out_pc), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    mem_acc  = imem_req && imem_ready;
    mem_addr = imem_addr;
  end

  always @(posedge clk) begin
    #1;
    imem_rvalid = mem_acc;
    imem_rdata  = 32'(mem_addr);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one tick after the first edge with rst low: cycle 0.
  task automatic do_reset(input logic rdy, input logic ordy);
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    imem_ready = rdy; out_ready = ordy;
    repeat (2) next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ready = 1'b1; out_ready = 1'b1;
    repeat (2) next_cycle();
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++;
    if (imem_addr !== 15'h0000) begin n_fail++; $display("FAIL reset_addr: got %h want 0000", imem_addr); end
    next_cycle();
  endtask

  task automatic test_stream();
    do_reset(1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== ADDR_W'(4*k)) begin
        n_fail++; $display("FAIL stream_req c%0d: got %b/%h want 1/%h", k, imem_req, imem_addr, ADDR_W'(4*k));
      end
      n_checks++;
      if (out_valid !== (k >= 2)) begin
        n_fail++; $display("FAIL stream_valid c%0d: got %b want %b", k, out_valid, (k >= 2));
      end
      if (k >= 2) begin
        n_checks++;
        if (out_pc !== ADDR_W'(4*(k-2)) || out_ins !== 32'(4*(k-2))) begin
          n_fail++; $display("FAIL stream_data c%0d: got %h/%h want %h", k, out_pc, out_ins, 4*(k-2));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b1, 1'b1);
    for (int k = 0; k < 18; k++) begin
      if (k == 4)  out_ready = 1'b0;
      if (k == 14) out_ready = 1'b1;
      @(negedge clk);
      if (k >= 4 && k < 14) begin
        n_checks++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_full_req c%0d: got %b want 0", k, imem_req); end
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 15'h0008) begin
          n_fail++; $display("FAIL bp_head c%0d: got %b/%h want 1/0008", k, out_valid, out_pc);
        end
      end else if (k >= 14) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== ADDR_W'(8 + 4*(k-14)) || out_ins !== 32'(8 + 4*(k-14))) begin
          n_fail++; $display("FAIL bp_drain c%0d: got %b/%h/%h want 1/%h", k, out_valid, out_pc, out_ins, 8 + 4*(k-14));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      redirect = (k == 3);
      redirect_pc = (k == 3) ? 15'h0103 : '0;
      @(negedge clk);
      case (k)
        3: begin
          n_checks++;
          if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_force c%0d: got %b want 0", k, out_valid); end
        end
        4: begin
          n_checks++;
          if (imem_req !== 1'b1 || imem_addr !== 15'h0100) begin
            n_fail++; $display("FAIL redir_target c%0d: got %b/%h want 1/0100", k, imem_req, imem_addr);
          end
          n_checks++;
          if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush c%0d: got %b want 0", k, out_valid); end
        end
        5: begin
          n_checks++;
          if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stale c%0d: got %b want 0", k, out_valid); end
        end
        6, 7: begin
          n_checks++;
          if (out_valid !== 1'b1 || out_pc !== ADDR_W'(32'h100 + 4*(k-6)) || out_ins !== 32'h100 + 32'(4*(k-6))) begin
            n_fail++; $display("FAIL redir_out c%0d: got %b/%h/%h want 1/%h", k, out_valid, out_pc, out_ins, 32'h100 + 4*(k-6));
          end
        end
        default: ;
      endcase
      next_cycle();
    end
    redirect = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1, 1'b1);
    for (int k = 0; k < 9; k++) begin
      redirect = (k == 3) || (k == 4);
      redirect_pc = (k == 3) ? 15'h0100 : (k == 4) ? 15'h0202 : '0;
      @(negedge clk);
      case (k)
        4, 6: begin
          n_checks++;
          if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid c%0d: got %b want 0", k, out_valid); end
        end
        5: begin
          n_checks++;
          if (imem_req !== 1'b1 || imem_addr !== 15'h0200) begin
            n_fail++; $display("FAIL b2b_target c%0d: got %b/%h want 1/0200", k, imem_req, imem_addr);
          end
        end
        7, 8: begin
          n_checks++;
          if (out_valid !== 1'b1 || out_pc !== ADDR_W'(32'h200 + 4*(k-7))) begin
            n_fail++; $display("FAIL b2b_out c%0d: got %b/%h want 1/%h", k, out_valid, out_pc, 32'h200 + 4*(k-7));
          end
        end
        default: ;
      endcase
      next_cycle();
    end
    redirect = 1'b0;
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_pc [3];
    exp_pc[0] = 15'h7FF8; exp_pc[1] = 15'h7FFC; exp_pc[2] = 15'h0000;
    do_reset(1'b1, 1'b1);
    for (int k = 0; k < 7; k++) begin
      redirect = (k == 1);
      redirect_pc = (k == 1) ? 15'h7FF8 : '0;
      @(negedge clk);
      if (k >= 2 && k <= 4) begin
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_pc[k-2]) begin
          n_fail++; $display("FAIL wrap_addr c%0d: got %b/%h want 1/%h", k, imem_req, imem_addr, exp_pc[k-2]);
        end
      end
      if (k >= 4) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== exp_pc[k-4] || out_ins !== 32'(exp_pc[k-4])) begin
          n_fail++; $display("FAIL wrap_out c%0d: got %b/%h/%h want 1/%h", k, out_valid, out_pc, out_ins, exp_pc[k-4]);
        end
      end
      next_cycle();
    end
    redirect = 1'b0;
  endtask

  task automatic test_stall_and_reset();
    do_reset(1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) imem_ready = 1'b1;
      rst = (k == 6);
      @(negedge clk);
      case (k)
        0, 1, 2, 3: begin
          n_checks++;
          if (imem_req !== 1'b1 || imem_addr !== 15'h0000) begin
            n_fail++; $display("FAIL stall_hold c%0d: got %b/%h want 1/0000", k, imem_req, imem_addr);
          end
        end
        4: begin
          n_checks++;
          if (imem_addr !== 15'h0004) begin n_fail++; $display("FAIL stall_adv c%0d: got %h want 0004", k, imem_addr); end
        end
        5: begin
          n_checks++;
          if (out_valid !== 1'b1 || out_pc !== 15'h0000) begin
            n_fail++; $display("FAIL stall_out c%0d: got %b/%h want 1/0000", k, out_valid, out_pc);
          end
        end
        6: begin
          n_checks++;
          if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++; $display("FAIL midrst c%0d: got valid %b req %b want 0/0", k, out_valid, imem_req);
          end
        end
        7: begin
          n_checks++;
          if (imem_req !== 1'b1 || imem_addr !== 15'h0000 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL refetch c%0d: got %b/%h valid %b want 1/0000/0", k, imem_req, imem_addr, out_valid);
          end
        end
        8: begin
          n_checks++;
          if (out_valid !== 1'b0) begin n_fail++; $display("FAIL refetch_gap c%0d: got %b want 0", k, out_valid); end
        end
        9: begin
          n_checks++;
          if (out_valid !== 1'b1 || out_pc !== 15'h0000) begin
            n_fail++; $display("FAIL refetch_out c%0d: got %b/%h want 1/0000", k, out_valid, out_pc);
          end
        end
        default: ;
      endcase
      next_cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_stall_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
